// File: rtl/jtag_tx_pkg.sv
// rtl/jtag_tx_pkg.sv - shared types, frame layout and helpers for the ER1 readback path
package jtag_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOADED   = 2'd1,
    SHIFTING = 2'd2
  } tx_state_t;

  // Frame header: bit0 valid, [7:1] occupancy after pop, data above.
  localparam int HDR_W     = 8;
  localparam int VALID_BIT = 0;
  localparam int LEVEL_LSB = 1;
  localparam int LEVEL_W   = 7;
  localparam int DATA_LSB  = 8;

  function automatic int frame_w(input int width);
    return width + HDR_W;
  endfunction

  // Occupancy as reported in the frame header, clamped to the 7-bit field.
  function automatic logic [LEVEL_W-1:0] sat_level(input int lvl);
    if (lvl > (1 << LEVEL_W) - 1) begin
      return {LEVEL_W{1'b1}};
    end
    return LEVEL_W'(lvl);
  endfunction

endpackage

// File: rtl/jtag_tx_fifo.sv
// rtl/jtag_tx_fifo.sv - synchronous DEPTH x WIDTH FIFO with first-word-fall-through read
module jtag_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jtag_readback_tx.sv
// rtl/jtag_readback_tx.sv - fabric-to-host ER1 readback; JTAG_TX_RETRY_EN re-presents short-shifted words
module jtag_readback_tx
  import jtag_tx_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             jtck,
  input  logic             jce1,
  input  logic             jshift,
  input  logic             jupdate,
  input  logic             jrstn,
  output logic             jtdo1,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [6:0]       level,
  output logic [7:0]       dropped
);

  localparam int FRAME_W = frame_w(WIDTH);
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]         jtck_q;
  logic [1:0]         jce1_q;
  logic [1:0]         jshift_q;
  logic [1:0]         jupdate_q;
  logic [1:0]         jrstn_q;
  logic               jtck_rise;
  logic               tap_rst;
  logic               ev_cap;
  logic               ev_sh;
  logic               ev_upd;

  tx_state_t          state;
  tx_state_t          state_next;
  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] sr_next;
  logic [FRAME_W-1:0] frame;
  logic [CNT_W-1:0]   bitcnt;
  logic               cur_valid;
  logic               do_load;
  logic               do_shift;
  logic               abort;
  logic               short_shift;
  logic               lost;
  logic               use_held;
  logic [WIDTH-1:0]   held_data;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [WIDTH-1:0]   fifo_rdata;
  logic [LVL_W-1:0]   fifo_level;

  assign fifo_push = s_valid & s_ready;
  assign s_ready   = ~fifo_full;
  assign level     = 7'(fifo_level);

  jtag_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Bring the JTAGG signals into the clock domain; jtck gets a third stage for edge detect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jtck_q    <= '0;
      jce1_q    <= '0;
      jshift_q  <= '0;
      jupdate_q <= '0;
      jrstn_q   <= '0;
    end else begin
      jtck_q    <= {jtck_q[1:0], jtck};
      jce1_q    <= {jce1_q[0], jce1};
      jshift_q  <= {jshift_q[0], jshift};
      jupdate_q <= {jupdate_q[0], jupdate};
      jrstn_q   <= {jrstn_q[0], jrstn};
    end
  end

  // Controls are taken from the same synchroniser depth as the jtck edge they qualify.
  assign jtck_rise = jtck_q[1] & ~jtck_q[2];
  assign tap_rst   = ~jrstn_q[1];
  assign ev_cap    = jtck_rise & jce1_q[1] & ~jshift_q[1];
  assign ev_sh     = jtck_rise & jce1_q[1] & jshift_q[1];
  assign ev_upd    = jtck_rise & jupdate_q[1];

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; TAP reset overrides every event.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ev_cap) state_next = LOADED;
      end
      LOADED, SHIFTING: begin
        if (ev_cap)      state_next = LOADED;
        else if (ev_sh)  state_next = SHIFTING;
        else if (ev_upd) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (tap_rst) state_next = IDLE;
  end

  // FSM outputs: load/shift strobes and the end of an in-flight word (abort).
  always_comb begin
    do_load  = 1'b0;
    do_shift = 1'b0;
    abort    = 1'b0;
    if (tap_rst) begin
      abort = (state != IDLE);
    end else begin
      case (state)
        IDLE: begin
          do_load = ev_cap;
        end
        LOADED, SHIFTING: begin
          do_load  = ev_cap;
          do_shift = ev_sh & ~ev_cap;
          abort    = ev_cap | ev_upd;
        end
        default: begin
          do_load = 1'b0;
        end
      endcase
    end
  end

  assign short_shift = abort & cur_valid & (bitcnt < CNT_W'(FRAME_W));
  assign fifo_pop    = do_load & ~use_held & ~fifo_empty;

  // Frame assembly: held word first, else FIFO head, else all zeros.
  always_comb begin
    frame = '0;
    if (use_held) begin
      frame[VALID_BIT]             = 1'b1;
      frame[LEVEL_LSB +: LEVEL_W]  = sat_level(int'(fifo_level));
      frame[DATA_LSB +: WIDTH]     = held_data;
    end else if (!fifo_empty) begin
      frame[VALID_BIT]             = 1'b1;
      frame[LEVEL_LSB +: LEVEL_W]  = sat_level(int'(fifo_level) - 1);
      frame[DATA_LSB +: WIDTH]     = fifo_rdata;
    end
  end

  // Next shift-register value; zeros enter at the top so overshift reads zeros.
  always_comb begin
    sr_next = sr;
    if (tap_rst) begin
      sr_next = '0;
    end else if (do_load) begin
      sr_next = frame;
    end else if (do_shift) begin
      sr_next = {1'b0, sr[FRAME_W-1:1]};
    end
  end

  // Shift register and bit counter; jtdo1 is loaded with the same value as sr[0].
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      jtdo1     <= 1'b0;
      bitcnt    <= '0;
      cur_valid <= 1'b0;
    end else begin
      sr    <= sr_next;
      jtdo1 <= sr_next[0];
      if (tap_rst) begin
        bitcnt    <= '0;
        cur_valid <= 1'b0;
      end else if (do_load) begin
        bitcnt    <= '0;
        cur_valid <= frame[VALID_BIT];
      end else if (do_shift && bitcnt != CNT_W'(FRAME_W)) begin
        bitcnt <= bitcnt + CNT_W'(1);
      end
    end
  end

`ifdef JTAG_TX_RETRY_EN
  logic held_valid;
  logic delivered;

  assign delivered = do_shift & cur_valid & (bitcnt == CNT_W'(FRAME_W - 1));
  assign use_held  = do_load & held_valid;
  // A valid in-flight word is always held, so a short shift never loses it.
  assign lost      = short_shift & ~held_valid;

  // Retry holding register: set on pop, released once the whole frame has shifted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_data  <= '0;
    end else if (fifo_pop) begin
      held_valid <= 1'b1;
      held_data  <= fifo_rdata;
    end else if (delivered) begin
      held_valid <= 1'b0;
    end
  end
`else
  assign use_held  = 1'b0;
  assign held_data = '0;
  assign lost      = short_shift;
`endif

  // Lost-word counter, saturating so the host can tell it wrapped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropped <= '0;
    end else if (lost && dropped != 8'hff) begin
      dropped <= dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_jtag_readback_tx.sv
// tb/tb_jtag_readback_tx.sv - scoreboard bench for jtag_readback_tx (honours JTAG_TX_RETRY_EN)
module tb_jtag_readback_tx;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;
  localparam int FRAME_W = WIDTH + 8;

  logic              clock   = 1'b0;
  logic              reset   = 1'b1;
  logic              jtck    = 1'b0;
  logic              jce1    = 1'b0;
  logic              jshift  = 1'b0;
  logic              jupdate = 1'b0;
  logic              jrstn   = 1'b1;
  logic              jtdo1;
  logic [WIDTH-1:0]  s_data  = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [6:0]        level;
  logic [7:0]        dropped;

  int checks = 0;
  int errors = 0;

  logic [FRAME_W-1:0] exp_q[$];
  logic [WIDTH-1:0]   model_fifo[$];
  logic [WIDTH-1:0]   held_m;
  logic               held_valid_m = 1'b0;
  logic               cur_valid_m  = 1'b0;
  logic               loaded_m     = 1'b0;
  int                 shifted_m    = 0;
  int                 dropped_m    = 0;

  always #5 clock = ~clock;

  jtag_readback_tx #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .jtck    (jtck),
    .jce1    (jce1),
    .jshift  (jshift),
    .jupdate (jupdate),
    .jrstn   (jrstn),
    .jtdo1   (jtdo1),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .level   (level),
    .dropped (dropped)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // End of an in-flight word as the host sees it.
  task automatic model_abort();
    if (loaded_m && cur_valid_m && shifted_m < FRAME_W) begin
`ifndef JTAG_TX_RETRY_EN
      dropped_m++;
`endif
    end
    loaded_m = 1'b0;
  endtask

  // One JTCK period: controls set with jtck low, TDO sampled just before the rise.
  task automatic jt_cycle(input logic ce, input logic sh, input logic up, output logic tdo);
    jce1    = ce;
    jshift  = sh;
    jupdate = up;
    #50;
    tdo  = jtdo1;
    jtck = 1'b1;
    #50;
    jtck = 1'b0;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    @(negedge clock);
    while (!s_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("push_ready", 64'(s_ready), 64'd1);
    if (s_ready) begin
      s_data  = d;
      s_valid = 1'b1;
      @(negedge clock);
      s_valid = 1'b0;
      model_fifo.push_back(d);
    end
  endtask

  task automatic capture();
    logic             t;
    logic [FRAME_W-1:0] f;
    logic [WIDTH-1:0] d;
    model_abort();
    f = '0;
    if (held_valid_m) begin
      f = {held_m, 7'(model_fifo.size()), 1'b1};
    end else if (model_fifo.size() > 0) begin
      d = model_fifo.pop_front();
      f = {d, 7'(model_fifo.size()), 1'b1};
`ifdef JTAG_TX_RETRY_EN
      held_m       = d;
      held_valid_m = 1'b1;
`endif
    end
    cur_valid_m = f[0];
    loaded_m    = 1'b1;
    shifted_m   = 0;
    exp_q.push_back(f);
    jt_cycle(1'b1, 1'b0, 1'b0, t);
  endtask

  task automatic shift_bits(input int n, output logic [63:0] bits);
    logic t;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      jt_cycle(1'b1, 1'b1, 1'b0, t);
      if (i < 64) bits[i] = t;
      shifted_m++;
      if (shifted_m == FRAME_W && cur_valid_m) held_valid_m = 1'b0;
    end
  endtask

  task automatic update();
    logic t;
    model_abort();
    jt_cycle(1'b0, 1'b0, 1'b1, t);
  endtask

  // Shift nbits and compare them against the oldest expected frame.
  task automatic read_frame(input string tag, input int nbits);
    logic [63:0]        bits;
    logic [FRAME_W-1:0] e;
    logic [63:0]        mask;
    shift_bits(nbits, bits);
    check({tag, "_sb"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      mask = (nbits >= FRAME_W) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
      check(tag, bits & mask, 64'(e) & mask);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    check("rst_jtdo1", 64'(jtdo1), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd1);
    check("rst_level", 64'(level), 64'd0);
    check("rst_dropped", 64'(dropped), 64'd0);

    // Single word round trip.
    push_word(32'hDEADBEEF);
    check("lvl_one", 64'(level), 64'd1);
    capture();
    check("lvl_after_cap", 64'(level), 64'd0);
    read_frame("frame_deadbeef", FRAME_W);
    update();

    // Capture with nothing queued yields zeros.
    capture();
    read_frame("frame_empty", FRAME_W);
    check("lvl_empty", 64'(level), 64'd0);
    update();

    // Fill to capacity, then drain.
    for (int i = 0; i < DEPTH; i++) push_word(32'h1000_0000 + 32'(i * 3));
    check("full_ready", 64'(s_ready), 64'd0);
    check("full_level", 64'(level), 64'(DEPTH));
    capture();
    check("ready_after_pop", 64'(s_ready), 64'd1);
    read_frame("frame_full0", FRAME_W);
    update();
    for (int i = 1; i < DEPTH; i++) begin
      capture();
      read_frame("frame_drain", FRAME_W);
      update();
    end
    check("drained_level", 64'(level), 64'd0);

    // Short shift followed by a full capture.
    push_word(32'hA5A5A5A5);
    capture();
    read_frame("frame_short", 10);
    update();
    capture();
    read_frame("frame_after_short", FRAME_W);
    update();
    check("dropped_short", 64'(dropped), 64'(dropped_m));

    // TAP reset in the middle of a shift.
    push_word(32'hFFFFFFFF);
    push_word(32'h22222222);
    capture();
    read_frame("frame_pre_jrst", 10);
    check("jtdo1_pre_jrst", 64'(jtdo1), 64'd1);
    jrstn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("jtdo1_jrst", 64'(jtdo1), 64'd0);
    model_abort();
    @(negedge clock);
    jrstn = 1'b1;
    repeat (5) @(negedge clock);
    capture();
    read_frame("frame_after_jrst", FRAME_W);
    update();
    check("dropped_jrst", 64'(dropped), 64'(dropped_m));
    for (int i = 0; i < DEPTH && model_fifo.size() > 0; i++) begin
      capture();
      read_frame("frame_flush", FRAME_W);
      update();
    end

    // Asynchronous reset while shifting with words queued.
    push_word(32'hFFFFFFFF);
    push_word(32'hFFFFFFFF);
    push_word(32'hFFFFFFFF);
    capture();
    read_frame("frame_pre_rst", 10);
    check("jtdo1_pre_rst", 64'(jtdo1), 64'd1);
    check("level_pre_rst", 64'(level), 64'd2);
    #3;
    reset = 1'b1;
    #1;
    check("arst_level", 64'(level), 64'd0);
    check("arst_jtdo1", 64'(jtdo1), 64'd0);
    check("arst_ready", 64'(s_ready), 64'd1);
    check("arst_dropped", 64'(dropped), 64'd0);
    model_fifo.delete();
    exp_q.delete();
    held_valid_m = 1'b0;
    loaded_m     = 1'b0;
    cur_valid_m  = 1'b0;
    dropped_m    = 0;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Path still works after reset.
    push_word(32'h12345678);
    capture();
    read_frame("frame_post_rst", FRAME_W);
    update();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
